// File: rtl/pwm_multi_if.sv
// Configuration handshake bundle for pwm_multi: the period, per-channel duty and
// alignment mode, offered with valid/ready.
interface pwm_multi_if #(
    parameter int N  = 16,
    parameter int CH = 4
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic [N-1:0]    cfg_period;
    logic [CH*N-1:0] cfg_duty;
    logic            cfg_center;

    modport master (output cfg_valid, cfg_period, cfg_duty, cfg_center, input cfg_ready);
    modport slave  (input cfg_valid, cfg_period, cfg_duty, cfg_center, output cfg_ready);
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel double-buffered PWM driven from one shared period counter.
// Center-aligned counting is built only when PWM_MULTI_CENTER_EN is defined.
module pwm_multi #(
    parameter int N  = 16,
    parameter int CH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable_i,
    pwm_multi_if.slave    cfg,
    output logic [CH-1:0] pwm_out_o,
    output logic [N-1:0]  count_o,
    output logic          cycle_start_o
);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]  count_q, count_d;
    logic [N-1:0]  period_q, period_d, period_sh_q;
    logic [N-1:0]  duty_q    [CH];
    logic [N-1:0]  duty_d    [CH];
    logic [N-1:0]  duty_sh_q [CH];
    logic [CH-1:0] pwm_q, pwm_d;
    logic          cs_q, cs_d;
    logic          pending_q, pending_d;
    logic          ready_q, run_q;
    logic          xfer, at_top, boundary, restart, apply, going_down;

`ifdef PWM_MULTI_CENTER_EN
    logic center_q, center_d, center_sh_q, down_q, down_d;
`else
    logic unused_center;
    assign unused_center = cfg.cfg_center;
`endif

    always_comb begin
        xfer   = cfg.cfg_valid && ready_q;
        at_top = (count_q == period_q);
`ifdef PWM_MULTI_CENTER_EN
        // At the top of a center-aligned period the next step is already downward.
        going_down = center_q && (down_q || at_top);
        boundary   = center_q ? ((period_q == '0) || (going_down && count_q == ONE)) : at_top;
`else
        going_down = 1'b0;
        boundary   = at_top;
`endif
        // Halted and first-enabled edges behave like boundaries: counter restarts at 0.
        restart   = !enable_i || !run_q || boundary;
        apply     = pending_q && restart;
        period_d  = apply ? period_sh_q : period_q;
        pending_d = xfer || (pending_q && !apply);

        count_d = count_q + ONE;
        cs_d    = 1'b0;
        if (!enable_i) begin
            count_d = '0;
        end else if (restart) begin
            count_d = '0;
            cs_d    = 1'b1;
        end else if (going_down) begin
            count_d = count_q - ONE;
        end
    end

`ifdef PWM_MULTI_CENTER_EN
    always_comb begin
        center_d = apply ? center_sh_q : center_q;
        down_d   = enable_i && !restart && going_down;
    end
`endif

    // Compare against the next count and next duty so outputs line up with count_o.
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            assign duty_d[gi] = apply ? duty_sh_q[gi] : duty_q[gi];
            assign pwm_d[gi]  = enable_i && (count_d < duty_d[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q     <= '0;
            period_q    <= '0;
            period_sh_q <= '0;
            pwm_q       <= '0;
            cs_q        <= 1'b0;
            pending_q   <= 1'b0;
            ready_q     <= 1'b1;
            run_q       <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                duty_q[i]    <= '0;
                duty_sh_q[i] <= '0;
            end
`ifdef PWM_MULTI_CENTER_EN
            center_q    <= 1'b0;
            center_sh_q <= 1'b0;
            down_q      <= 1'b0;
`endif
        end else begin
            count_q   <= count_d;
            period_q  <= period_d;
            pwm_q     <= pwm_d;
            cs_q      <= cs_d;
            pending_q <= pending_d;
            ready_q   <= !pending_d;
            run_q     <= enable_i;
            for (int i = 0; i < CH; i++) begin
                duty_q[i] <= duty_d[i];
            end
            if (xfer) begin
                period_sh_q <= cfg.cfg_period;
                for (int i = 0; i < CH; i++) begin
                    duty_sh_q[i] <= cfg.cfg_duty[i*N +: N];
                end
`ifdef PWM_MULTI_CENTER_EN
                center_sh_q <= cfg.cfg_center;
`endif
            end
`ifdef PWM_MULTI_CENTER_EN
            center_q <= center_d;
            down_q   <= down_d;
`endif
        end
    end

    assign pwm_out_o     = pwm_q;
    assign count_o       = count_q;
    assign cycle_start_o = cs_q;
    assign cfg.cfg_ready = ready_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: period-phase model checked every cycle plus directed literal checks,
// and a second 4-bit instance for the full-range wrap.
`timescale 1ns/1ps
module tb_pwm_multi;
    localparam int N  = 16;
    localparam int CH = 4;
`ifdef PWM_MULTI_CENTER_EN
    localparam bit CENTER_EN = 1'b1;
    int exp_cnt [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    int exp_pw  [8] = '{1, 1, 0, 0, 0, 0, 0, 1};
`else
    localparam bit CENTER_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable_a = 1'b0;
    logic enable_b = 1'b0;
    logic [CH-1:0] pwm_a;
    logic [N-1:0]  count_a;
    logic          cs_a;
    logic [0:0]    pwm_b;
    logic [3:0]    count_b;
    logic          cs_b;

    pwm_multi_if #(.N(N), .CH(CH)) if_a ();
    pwm_multi_if #(.N(4), .CH(1))  if_b ();

    pwm_multi #(.N(N), .CH(CH)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_a), .cfg(if_a),
        .pwm_out_o(pwm_a), .count_o(count_a), .cycle_start_o(cs_a)
    );
    pwm_multi #(.N(4), .CH(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_b), .cfg(if_b),
        .pwm_out_o(pwm_b), .count_o(count_b), .cycle_start_o(cs_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model: phase index within the period ----------------
    int m_P, m_shP, m_k;
    int m_D [CH];
    int m_shD [CH];
    bit m_c, m_shc, m_pend, m_run, m_en;
    bit live = 1'b0;
    logic [N-1:0]  m_count;
    logic [CH-1:0] m_pwm;
    logic          m_cs, m_ready;

    function automatic int period_of(input int p, input bit c);
        if (c) return (p == 0) ? 1 : 2 * p;
        return p + 1;
    endfunction

    function automatic int count_at(input int k, input int p, input bit c);
        if (c && k > p) return 2 * p - k;
        return k;
    endfunction

    task automatic model_apply();
        m_P = m_shP;
        m_c = m_shc;
        for (int i = 0; i < CH; i++) m_D[i] = m_shD[i];
        m_pend = 1'b0;
    endtask

    task automatic model_step();
        bit xfer;
        int c;
        if (!reset_n) begin
            m_P = 0; m_shP = 0; m_k = 0; m_c = 0; m_shc = 0;
            m_pend = 0; m_run = 0; m_en = 0; m_cs = 0;
            for (int i = 0; i < CH; i++) begin m_D[i] = 0; m_shD[i] = 0; end
        end else begin
            xfer = if_a.cfg_valid && !m_pend;
            m_en = enable_a;
            if (!enable_a) begin
                if (m_pend) model_apply();
                m_run = 0; m_k = 0; m_cs = 0;
            end else begin
                if (!m_run || m_k == period_of(m_P, m_c) - 1) begin
                    if (m_pend) model_apply();
                    m_k = 0; m_cs = 1;
                end else begin
                    m_k++; m_cs = 0;
                end
                m_run = 1;
            end
            if (xfer) begin
                m_shP = int'(if_a.cfg_period);
                for (int i = 0; i < CH; i++) m_shD[i] = int'(if_a.cfg_duty[i*N +: N]);
                m_shc = CENTER_EN && if_a.cfg_center;
                m_pend = 1;
            end
        end
        c = m_en ? count_at(m_k, m_P, m_c) : 0;
        m_count = 16'(c);
        for (int i = 0; i < CH; i++) m_pwm[i] = m_en && (c < m_D[i]);
        m_ready = !m_pend;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            live = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("model_count", 32'(count_a), 32'(m_count));
            chk("model_pwm", 32'(pwm_a), 32'(m_pwm));
            chk("model_cycle_start", 32'(cs_a), 32'(m_cs));
            chk("model_cfg_ready", 32'(if_a.cfg_ready), 32'(m_ready));
        end
    end

    // ---------------- stimulus helpers ----------------
    int meas_len;
    int meas_hi [CH];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cfg(input int p, input int d0, input int d1, input int d2, input int d3,
                            input bit c, output int waited);
        if_a.cfg_valid  = 1'b1;
        if_a.cfg_period = 16'(p);
        if_a.cfg_duty   = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
        if_a.cfg_center = c;
        waited = 0;
        while (!if_a.cfg_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) timeout("cfg_accept");
        @(negedge clk);
        if_a.cfg_valid = 1'b0;
    endtask

    task automatic wait_count(input int v);
        int n = 0;
        while (int'(count_a) != v && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout("wait_count");
    endtask

    task automatic wait_cs();
        int n = 0;
        while (!cs_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout("wait_cycle_start");
    endtask

    task automatic measure();
        wait_cs();
        meas_len = 0;
        for (int i = 0; i < CH; i++) meas_hi[i] = 0;
        do begin
            for (int i = 0; i < CH; i++) meas_hi[i] += int'(pwm_a[i]);
            meas_len++;
            @(negedge clk);
        end while (!cs_a && meas_len < 200);
    endtask

    initial begin
        int w, h, n;
        if_a.cfg_valid = 0; if_a.cfg_period = '0; if_a.cfg_duty = '0; if_a.cfg_center = 0;
        if_b.cfg_valid = 0; if_b.cfg_period = '0; if_b.cfg_duty = '0; if_b.cfg_center = 0;

        // Reset values
        tick(3);
        chk("reset_count", 32'(count_a), 0);
        chk("reset_pwm", 32'(pwm_a), 0);
        chk("reset_cycle_start", 32'(cs_a), 0);
        chk("reset_cfg_ready", 32'(if_a.cfg_ready), 1);

        // Defaults running: P=0 gives a boundary every cycle
        reset_n = 1; enable_a = 1;
        tick(1);
        for (int j = 0; j < 4; j++) begin
            chk("default_cs", 32'(cs_a), 1);
            chk("default_count", 32'(count_a), 0);
            chk("default_pwm", 32'(pwm_a), 0);
            tick(1);
        end

        // Edge mode P=9, D={0,3,10,5}
        send_cfg(9, 0, 3, 10, 5, 0, w);
        chk("accept_immediate", 32'(w), 0);
        tick(1);
        measure();
        chk("edge_period", 32'(meas_len), 10);
        chk("edge_hi_ch0", 32'(meas_hi[0]), 0);
        chk("edge_hi_ch1", 32'(meas_hi[1]), 3);
        chk("edge_hi_ch2", 32'(meas_hi[2]), 10);
        chk("edge_hi_ch3", 32'(meas_hi[3]), 5);

        // Mid-period reload at count 4, then a second request held while pending
        wait_count(4);
        send_cfg(9, 0, 7, 10, 5, 0, w);
        chk("reload_ready_low", 32'(if_a.cfg_ready), 0);
        chk("reload_old_duty_kept", 32'(pwm_a[1]), 0);
        send_cfg(9, 0, 2, 10, 5, 0, w);
        chk("held_request_wait", 32'(w), 5);
        chk("new_duty_high", 32'(pwm_a[1]), 1);
        h = 0; n = 0;
        while (!cs_a && n < 20) begin
            h += int'(pwm_a[1]);
            tick(1);
            n++;
        end
        chk("reload_pulse_rest", 32'(h), 6);
        measure();
        chk("second_reload_period", 32'(meas_len), 10);
        chk("second_reload_ch1", 32'(meas_hi[1]), 2);

        // Reset mid-period with a pending shadow
        send_cfg(5, 1, 1, 1, 1, 0, w);
        wait_count(6);
        reset_n = 0;
        tick(1);
        chk("rst_mid_count", 32'(count_a), 0);
        chk("rst_mid_pwm", 32'(pwm_a), 0);
        chk("rst_mid_cs", 32'(cs_a), 0);
        chk("rst_mid_ready", 32'(if_a.cfg_ready), 1);
        enable_a = 0; reset_n = 1;
        tick(2);
        enable_a = 1;
        tick(1);
        chk("reenable_count", 32'(count_a), 0);
        chk("reenable_cs", 32'(cs_a), 1);
        tick(3);
        chk("shadow_discarded", 32'(count_a), 0);
        chk("shadow_discarded_cs", 32'(cs_a), 1);

        // Disable mid-run
        send_cfg(9, 0, 3, 10, 5, 0, w);
        wait_count(5);
        enable_a = 0;
        tick(1);
        chk("disable_count", 32'(count_a), 0);
        chk("disable_pwm", 32'(pwm_a), 0);
        chk("disable_cs", 32'(cs_a), 0);
        enable_a = 1;
        tick(1);
        chk("first_en_count", 32'(count_a), 0);
        chk("first_en_cs", 32'(cs_a), 1);
        chk("first_en_pwm", 32'(pwm_a), 32'h0000000e);

        // D > P is constant high
        send_cfg(3, 4, 16'hffff, 3, 1, 0, w);
        measure();
        chk("dgtp_period", 32'(meas_len), 4);
        chk("dgtp_ch0", 32'(meas_hi[0]), 4);
        chk("dgtp_ch1", 32'(meas_hi[1]), 4);
        chk("dgtp_ch2", 32'(meas_hi[2]), 3);
        chk("dgtp_ch3", 32'(meas_hi[3]), 1);

        // Center request, P=4, D=2
        send_cfg(4, 2, 2, 2, 2, 1, w);
`ifdef PWM_MULTI_CENTER_EN
        wait_cs();
        for (int j = 0; j < 8; j++) begin
            chk("center_count", 32'(count_a), 32'(exp_cnt[j]));
            chk("center_pwm", 32'(pwm_a[0]), 32'(exp_pw[j]));
            tick(1);
        end
        chk("center_period8", 32'(cs_a), 1);
`else
        measure();
        chk("center_ignored_period", 32'(meas_len), 5);
        chk("center_ignored_hi", 32'(meas_hi[0]), 2);
`endif

        // N=4 full-range wrap, P=15, D=15
        if_b.cfg_valid = 1; if_b.cfg_period = 4'd15; if_b.cfg_duty = 4'd15;
        tick(1);
        if_b.cfg_valid = 0;
        tick(1);
        enable_b = 1;
        tick(1);
        for (int k = 0; k < 16; k++) begin
            chk("wrap_count", 32'(count_b), 32'(k));
            chk("wrap_pwm", 32'(pwm_b), (k != 15) ? 32'd1 : 32'd0);
            chk("wrap_cs", 32'(cs_b), (k == 0) ? 32'd1 : 32'd0);
            tick(1);
        end
        chk("wrap_restart_count", 32'(count_b), 0);
        chk("wrap_restart_cs", 32'(cs_b), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, double-buffered PWM generator. It drives CH outputs from one shared N-bit period counter. The period, per-channel duty and alignment mode are loaded through a valid/ready configuration port. They take effect only at a period boundary, so no output ever shows a glitched or truncated pulse. The block sits between the register/control logic and the LED, motor or servo pins, and replaces the single-channel PWM with a fixed period.

## Interface
- N, 16: counter, period and duty width in bits (N >= 2).
- CH, 4: number of PWM channels (CH >= 1).
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- enable  in  1  1 = run counter; 0 = halt, counter and outputs forced low.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  shadow register free; transfer occurs when cfg_valid && cfg_ready at rising edge.
- cfg_period  in  N  terminal count P.
- cfg_duty  in  CH*N  duty D[i] in bits [i*N +: N].
- cfg_center  in  1  0 = edge-aligned, 1 = center-aligned.
- pwm_out  out  CH  registered PWM outputs.
- count  out  N  current counter value (registered).
- cycle_start  out  1  high for the one cycle in which count == 0 at the start of a period.

## Operation
- **Reset values:**
  - pwm_out = 0, count = 0, cycle_start = 0, cfg_ready = 1.
  - Active P = 0, all D = 0, mode edge, up-direction, no pending shadow.
- **Handshake:**
  - On transfer, cfg_* are captured into the shadow and the pending flag is set.
  - cfg_ready = ~pending (registered).
  - cfg_valid while cfg_ready = 0 is ignored; the master must hold the request.
- **Apply:**
  - The pending shadow is copied to the active set at the first boundary edge strictly after the capture edge.
  - On the same edge, pending is cleared and the counter restarts at 0, direction up.
  - While enable = 0, a pending shadow applies on the next edge.
- **Edge mode:**
  - count runs 0,1,…,P, then 0. The period is P+1 cycles.
  - The boundary is the edge leaving count == P.
- **Center mode:**
  - count runs 0,1,…,P,P-1,…,1, then 0. The period is 2P cycles.
  - The boundary is the edge leaving count == 1 while counting down.
  - If P = 0, count stays 0 and every edge is a boundary.
- **Compare:**
  - pwm_out[i] == (count < D[i]), unsigned N-bit, in every enabled cycle. It is computed from the next count, so it is aligned with count and has no extra lag.
  - D = 0 gives constant low.
  - D > P gives constant high (edge and center).
- **Wrap:**
  - The terminal test uses equality (count == P), never count+1 > P.
  - P = 2^N-1 gives a full 2^N period with no overflow skip.
- **Disable:**
  - enable = 0 forces count = 0, pwm_out = 0, cycle_start = 0 and direction up from the next edge.
  - On the first enabled edge, count = 0, pwm_out[i] = (D[i] != 0) and cycle_start = 1.
- **Reset mid-period:** reset returns all state to reset values on the next edge and discards any pending shadow.

## Timing
- Config-to-output latency: at least 1 and at most one full period + 1 cycle after transfer.
- cycle_start is asserted exactly in the cycle after each boundary edge and after the first enabled edge; otherwise it is 0.
- A transfer on the boundary edge itself applies at the following boundary.
- cfg_ready returns to 1 in the cycle after apply. The earliest next transfer is on that cycle's edge.

## Configuration
- PWM_MULTI_CENTER_EN defined: center-aligned mode is available as specified above.
- Not defined:
  - cfg_center is ignored and the mode is always edge-aligned.
  - Up/down direction logic is removed.
  - All other behaviour is unchanged.

## Test plan
- Reset, enable = 1 with defaults: pwm_out = 0 constantly, count = 0, cycle_start = 1 every cycle, cfg_ready = 1.
- N=16, CH=4, edge mode, P=9, D={0,3,10,5}:
  - period is 10 cycles;
  - ch0 is always low;
  - ch1 is high for 3 cycles per period;
  - ch2 is always high;
  - ch3 is high for counts 0–4.
- Mid-period reload: running P=9 with D1=3, transfer D1=7 at count = 4.
  - cfg_ready stays 0 until the boundary.
  - The current period keeps the 3-cycle pulse.
  - The next period begins with a 7-cycle pulse.
  - A second cfg_valid held during pending is accepted only after cfg_ready rises.
- Center mode (macro defined), P=4, D=2:
  - count sequence 0,1,2,3,4,3,2,1 repeats;
  - pwm_out high at counts 0,1 and 1, giving a symmetric pulse;
  - period is 8 cycles.
- N=4, P=15, D=15:
  - period is 16 cycles;
  - pwm_out is low only at count 15;
  - no skipped wrap.
- Assert reset_n = 0 at count 6 with a pending shadow, then drop enable:
  - all outputs reach reset values next cycle;
  - the shadow is discarded;
  - re-enable restarts at count 0 with cycle_start = 1.
